// File: rtl/decode38_seq_pkg.sv
// Shared definitions for the 3-to-8 decoder and its companion 8-to-3 encoder.
package decode38_seq_pkg;

  localparam int CODE_W  = 3;
  localparam int NUM_OUT = 8;

  // Controller state encoding (kept as plain constants for legacy tools).
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HOLD = 2'd1;
  localparam logic [1:0] SCAN = 2'd2;

  // One-hot pattern selected by a code.
  function automatic logic [NUM_OUT-1:0] onehot(input logic [CODE_W-1:0] code);
    onehot = {{(NUM_OUT-1){1'b0}}, 1'b1} << code;
  endfunction

  // True when v is zero or has exactly one bit set.
  function automatic logic is_onehot0(input logic [NUM_OUT-1:0] v);
    is_onehot0 = ((v & (v - {{(NUM_OUT-1){1'b0}}, 1'b1})) == {NUM_OUT{1'b0}});
  endfunction

endpackage

// File: rtl/decode38_seq_if.sv
// Code-in / pattern-out bus of the sequenced decoder.
interface decode38_seq_if;
  import decode38_seq_pkg::*;

  logic               a_valid;
  logic [CODE_W-1:0]  a;
  logic               a_ready;
  logic [NUM_OUT-1:0] d;
  logic               d_valid;
  logic [CODE_W-1:0]  code_out;

  modport master (output a_valid, a, input a_ready, d, d_valid, code_out);
  modport slave  (input a_valid, a, output a_ready, d, d_valid, code_out);

endinterface

// File: rtl/decode38_seq_chk.sv
// Output sanity checks for decode38_seq: d is zero or one-hot, and d_valid tracks it.
module decode38_seq_chk
  import decode38_seq_pkg::*;
(
  input logic               clk,
  input logic               rst_n,
  input logic [NUM_OUT-1:0] d,
  input logic               d_valid
);

  a_d_onehot0: assert property (@(posedge clk) disable iff (!rst_n) is_onehot0(d));
  a_d_valid:   assert property (@(posedge clk) disable iff (!rst_n) d_valid == (d != {NUM_OUT{1'b0}}));

endmodule

// File: rtl/decode38_seq_hold_timer.sv
// Loadable down-counter that flags when a pattern slot has run out.
module hold_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] count_r;

  // Count down to zero and stay there; clear wins over load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {CNT_W{1'b0}};
    end else if (clear) begin
      count_r <= {CNT_W{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (count_r != {CNT_W{1'b0}}) begin
      count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign done = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/decode38_seq.sv
// Sequenced 3-to-8 decoder: handshake-driven one-hot pulses or auto-scan.
module decode38_seq
  import decode38_seq_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          scan,
  output logic          busy,
  decode38_seq_if.slave bus
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_CYCLES - 1);

  logic [1:0]         state_r, state_s;
  logic [NUM_OUT-1:0] d_r, d_s;
  logic               d_valid_r, d_valid_s;
  logic [CODE_W-1:0]  code_r, code_s;
  logic [CODE_W-1:0]  code_inc_s;
  logic               load_s, clear_s, done_s;

  hold_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear_s),
    .load     (load_s),
    .load_val (RELOAD),
    .done     (done_s)
  );

  assign code_inc_s   = code_r + {{(CODE_W-1){1'b0}}, 1'b1};
  assign bus.a_ready  = (state_r == IDLE) && en && !scan;
  assign bus.d        = d_r;
  assign bus.d_valid  = d_valid_r;
  assign bus.code_out = code_r;
  assign busy         = (state_r != IDLE);

  // Next-state and next-output decision; en low overrides everything.
  always_comb begin
    state_s   = state_r;
    d_s       = d_r;
    d_valid_s = d_valid_r;
    code_s    = code_r;
    load_s    = 1'b0;
    clear_s   = 1'b0;
    if (!en) begin
      state_s   = IDLE;
      d_s       = {NUM_OUT{1'b0}};
      d_valid_s = 1'b0;
      clear_s   = 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (scan) begin
            state_s   = SCAN;
            code_s    = {CODE_W{1'b0}};
            d_s       = onehot({CODE_W{1'b0}});
            d_valid_s = 1'b1;
            load_s    = 1'b1;
          end else if (bus.a_valid) begin
            state_s   = HOLD;
            code_s    = bus.a;
            d_s       = onehot(bus.a);
            d_valid_s = 1'b1;
            load_s    = 1'b1;
          end else begin
            state_s = IDLE;
          end
        end
        HOLD: begin
          if (done_s) begin
            state_s   = IDLE;
            d_s       = {NUM_OUT{1'b0}};
            d_valid_s = 1'b0;
          end else begin
            state_s = HOLD;
          end
        end
        SCAN: begin
          if (done_s && scan) begin
            code_s = code_inc_s;
            d_s    = onehot(code_inc_s);
            load_s = 1'b1;
          end else if (done_s) begin
            state_s   = IDLE;
            d_s       = {NUM_OUT{1'b0}};
            d_valid_s = 1'b0;
          end else begin
            state_s = SCAN;
          end
        end
        default: begin
          state_s   = IDLE;
          d_s       = {NUM_OUT{1'b0}};
          d_valid_s = 1'b0;
          clear_s   = 1'b1;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      d_r       <= {NUM_OUT{1'b0}};
      d_valid_r <= 1'b0;
      code_r    <= {CODE_W{1'b0}};
    end else begin
      state_r   <= state_s;
      d_r       <= d_s;
      d_valid_r <= d_valid_s;
      code_r    <= code_s;
    end
  end

endmodule

// File: tb/tb_decode38_seq.sv
// Randomized and directed bench for decode38_seq, HOLD_CYCLES=4 and HOLD_CYCLES=1 side by side.
module tb_decode38_seq;
  import decode38_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n, en, scan, a_valid;
  logic [2:0] a;
  logic       busy4, busy1;
  int         n_checks = 0;
  int         n_pass = 0;

  // behavioural model: per DUT, whether a pattern is live, whether it came from scan,
  // how many cycles remain in the slot, and the current code
  int hold_n [2] = '{4, 1};
  int m_busy [2];
  int m_scan [2];
  int m_left [2];
  int m_code [2];
  logic [7:0] last_d4;

  decode38_seq_if bus4();
  decode38_seq_if bus1();

  assign bus4.a_valid = a_valid;
  assign bus4.a       = a;
  assign bus1.a_valid = a_valid;
  assign bus1.a       = a;

  always #5 clk = ~clk;

  decode38_seq #(.HOLD_CYCLES(4), .CNT_W(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .scan(scan), .busy(busy4), .bus(bus4.slave));
  decode38_seq #(.HOLD_CYCLES(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .scan(scan), .busy(busy1), .bus(bus1.slave));

  decode38_seq_chk chk4 (.clk(clk), .rst_n(rst_n), .d(bus4.d), .d_valid(bus4.d_valid));
  decode38_seq_chk chk1 (.clk(clk), .rst_n(rst_n), .d(bus1.d), .d_valid(bus1.d_valid));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic logic [7:0] exp_d(input int i);
    if (m_busy[i] != 0) return 8'(2 ** m_code[i]);
    return 8'd0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 0; m_scan[i] = 0; m_left[i] = 0; m_code[i] = 0;
    end
  endtask

  // advance the model by one clock edge using the currently driven inputs
  task automatic model_step(input int i);
    if (!en) begin
      m_busy[i] = 0;
    end else if (m_busy[i] == 0) begin
      if (scan) begin
        m_busy[i] = 1; m_scan[i] = 1; m_code[i] = 0; m_left[i] = hold_n[i];
      end else if (a_valid) begin
        m_busy[i] = 1; m_scan[i] = 0; m_code[i] = int'(a); m_left[i] = hold_n[i];
      end
    end else begin
      m_left[i]--;
      if (m_left[i] == 0) begin
        if (m_scan[i] != 0 && scan) begin
          m_code[i] = (m_code[i] + 1) % 8;
          m_left[i] = hold_n[i];
        end else begin
          m_busy[i] = 0;
        end
      end
    end
  endtask

  task automatic check_dut(input int i, input logic [7:0] d, input logic dv,
                           input logic [2:0] co, input logic b);
    check($sformatf("d_h%0d", hold_n[i]), 32'(d), 32'(exp_d(i)));
    check($sformatf("d_valid_h%0d", hold_n[i]), 32'(dv), 32'(m_busy[i] != 0));
    check($sformatf("code_out_h%0d", hold_n[i]), 32'(co), 32'(m_code[i]));
    check($sformatf("busy_h%0d", hold_n[i]), 32'(b), 32'(m_busy[i] != 0));
  endtask

  // one clock: check registered outputs, drive new inputs, check a_ready, step the model
  task automatic cycle(input logic en_v, input logic scan_v, input logic av_v, input logic [2:0] a_v);
    @(negedge clk);
    check_dut(0, bus4.d, bus4.d_valid, bus4.code_out, busy4);
    check_dut(1, bus1.d, bus1.d_valid, bus1.code_out, busy1);
    last_d4 = bus4.d;
    en = en_v; scan = scan_v; a_valid = av_v; a = a_v;
    #1;
    check("a_ready_h4", 32'(bus4.a_ready), 32'(m_busy[0] == 0 && en && !scan));
    check("a_ready_h1", 32'(bus1.a_ready), 32'(m_busy[1] == 0 && en && !scan));
    model_step(0);
    model_step(1);
  endtask

  initial begin
    int cnt;
    logic [7:0] prev;
    logic saw_wrap;
    logic s;

    rst_n = 1'b0; en = 1'b0; scan = 1'b0; a_valid = 1'b0; a = 3'd0;
    model_reset();
    #1;
    check("rst_d", 32'(bus4.d), 32'h0);
    check("rst_d_valid", 32'(bus4.d_valid), 32'h0);
    check("rst_code_out", 32'(bus4.code_out), 32'h0);
    check("rst_busy", 32'(busy4), 32'h0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1; en = 1'b1;

    // handshake decode of code 5: pattern lasts exactly 4 cycles
    cycle(1'b1, 1'b0, 1'b1, 3'd5);
    cnt = 0;
    for (int k = 0; k < 7; k++) begin
      cycle(1'b1, 1'b0, 1'b0, 3'd0);
      if (last_d4 == 8'h20) cnt++;
    end
    check("hs_len", 32'(cnt), 32'd4);

    // back-to-back codes 0 then 7 with a_valid held
    cycle(1'b1, 1'b0, 1'b1, 3'd0);
    for (int k = 0; k < 10; k++) cycle(1'b1, 1'b0, 1'b1, 3'd7);
    for (int k = 0; k < 6; k++) cycle(1'b1, 1'b0, 1'b0, 3'd0);

    // scan for 36 cycles, watching for the 80 -> 01 wrap
    prev = 8'h00; saw_wrap = 1'b0;
    for (int k = 0; k < 36; k++) begin
      cycle(1'b1, 1'b1, 1'b0, 3'd0);
      if (prev == 8'h80 && last_d4 == 8'h01) saw_wrap = 1'b1;
      prev = last_d4;
    end
    check("scan_wrap", 32'(saw_wrap), 32'd1);
    for (int k = 0; k < 6; k++) cycle(1'b1, 1'b0, 1'b0, 3'd0);

    // scan released in the second cycle of the code-3 slot
    for (int k = 0; k < 14; k++) cycle(1'b1, 1'b1, 1'b0, 3'd0);
    for (int k = 0; k < 6; k++) cycle(1'b1, 1'b0, 1'b0, 3'd0);

    // abort during HOLD of code 2, then scan beats a simultaneous a_valid
    cycle(1'b1, 1'b0, 1'b1, 3'd2);
    cycle(1'b1, 1'b0, 1'b0, 3'd0);
    cycle(1'b0, 1'b0, 1'b0, 3'd0);
    cycle(1'b1, 1'b0, 1'b0, 3'd0);
    cycle(1'b1, 1'b1, 1'b1, 3'd4);
    cycle(1'b1, 1'b1, 1'b0, 3'd0);
    for (int k = 0; k < 6; k++) cycle(1'b1, 1'b0, 1'b0, 3'd0);

    // asynchronous reset between edges while scanning
    for (int k = 0; k < 10; k++) cycle(1'b1, 1'b1, 1'b0, 3'd0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_d", 32'(bus4.d), 32'h0);
    check("arst_d_valid", 32'(bus4.d_valid), 32'h0);
    check("arst_code_out", 32'(bus4.code_out), 32'h0);
    check("arst_busy", 32'(busy4), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1; scan = 1'b0;
    cycle(1'b1, 1'b0, 1'b0, 3'd0);
    cycle(1'b1, 1'b0, 1'b1, 3'd6);

    // randomized traffic
    s = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 9) == 0) s = ~s;
      cycle(($urandom_range(0, 19) != 0), s, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
    end
    for (int k = 0; k < 6; k++) cycle(1'b1, 1'b0, 1'b0, 3'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/decode38_seq.md
Name: decode38_seq

Overview:
- Sequenced 3-to-8 decoder; the output-side counterpart of the team's 8-to-3 encoder.
- Accepts a 3-bit code over a valid/ready handshake and drives the matching one-hot 8-bit pattern for a programmable number of cycles.
- Auto-scan mode steps codes 0..7 repeatedly, acting as a one-hot pattern generator for encoder checks and display/LED select lines.

Parameters:
- HOLD_CYCLES, 4, cycles each one-hot pattern stays asserted (legal range 1..255).
- CNT_W, 8, width of the hold counter (must hold HOLD_CYCLES-1).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- en  input  1  block enable; low aborts any activity.
- scan  input  1  request auto-scan mode.
- a_valid  input  1  code valid.
- a  input  3  code to decode.
- a_ready  output  1  code accepted when a_valid && a_ready at a rising edge.
- d  output  8  registered one-hot output; 0 when idle.
- d_valid  output  1  d carries a live pattern.
- code_out  output  3  code currently driven on d.
- busy  output  1  state != IDLE.

Behaviour:
- Reset values: d=8'h00, d_valid=0, code_out=3'd0, hold counter=0, state IDLE. Reset acts immediately, mid-operation included.
- States: IDLE, HOLD, SCAN.
- a_ready is combinational and equals (state==IDLE) && en && !scan.
- IDLE->HOLD on a_valid && a_ready:
  - Next edge: d = 8'b1 << a, code_out = a, d_valid = 1, counter = HOLD_CYCLES-1.
  - Latency is 1 cycle from handshake to d.
- HOLD: the counter decrements each cycle. When counter==0, the next edge sets d=0, d_valid=0 and returns to IDLE.
  - d is therefore high for exactly HOLD_CYCLES cycles.
  - The minimum gap between patterns is 1 IDLE cycle.
  - a_valid is ignored in HOLD and a_ready is low.
- IDLE->SCAN when en && scan:
  - Next edge: code_out=0, d=8'h01, d_valid=1, counter=HOLD_CYCLES-1.
  - scan has priority over a simultaneous a_valid, because a_ready is low.
- SCAN slot expiry (counter==0):
  - If scan is still high: code_out increments mod 8 (7 wraps to 0), d = 1<<code_out_next, counter reloads. d_valid stays 1 with no gap.
  - If scan is low: d=0, d_valid=0, return to IDLE. The current slot always completes.
- en low in any state: the next edge forces d=0, d_valid=0, state IDLE. code_out holds its last value. en has priority over every other event.
- HOLD_CYCLES=1:
  - Handshake mode gives a 1-cycle pulse followed by a 1-cycle gap.
  - Scan advances one code per cycle.
- d is always 0 or exactly one-hot. Any other value is an error, covered by an assertion.
- No combinational path from a to d.

Decomposition:
- Shared package holds:
  - state encoding constants IDLE=2'd0, HOLD=2'd1, SCAN=2'd2;
  - CODE_W=3 and NUM_OUT=8.
- The encoder bench reuses the same package.
- One sub-module, hold_timer: a loadable down-counter with ports load, load_val, and a done flag when it reaches 0. It is instantiated once.

Test Plan (HOLD_CYCLES=4, en=1 unless stated):
- Handshake decode: a=3'd5 with a_valid for 1 cycle -> a_ready=1 that cycle; d=8'b00100000, code_out=5, d_valid=1 for exactly 4 cycles starting 1 cycle later; then d=0 and a_ready=1 again.
- Back-to-back codes: hold a_valid with a=0 then a=7 -> d=8'h01 for 4 cycles, 1 idle cycle, then d=8'h80 for 4 cycles; a_ready is low throughout HOLD.
- Scan with wrap: scan=1 for 36 cycles -> d sequence 01,02,04,08,10,20,40,80,01 with 4 cycles each and d_valid continuously 1; 8'h80 is followed by 8'h01.
- Scan release mid-slot: drop scan in the 2nd cycle of the code-3 slot -> d=8'h08 completes all 4 cycles, then d=0, busy=0.
- Abort and priority: en=0 during HOLD of code 2 -> d=0 on the next edge, state IDLE. With scan=1 and a_valid=1 together in IDLE -> a_ready=0 and the first output is 8'h01.
- Async reset: assert rst_n=0 between clock edges during SCAN -> d=0, d_valid=0, code_out=0, busy=0 immediately. Release -> IDLE, and a_ready=1 once scan is low.
